// File: rtl/usb_mode_controller.sv
// rtl/usb_mode_controller.sv - USB command decoder and run sequencer for the acquisition mode switcher
// Mode/DAC routing is only writable in IDLE so the switcher never re-routes during a run.
module usb_mode_controller #(
   parameter int unsigned STOP_HOLD = 8
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic [15:0] CommandWord,
   input  logic        CommandWord_en,
   input  logic        SweepTestDone,
   output logic [1:0]  ModeSelect,
   output logic [1:0]  DacSelect,
   output logic        UsbMicrorocAcqStartStop,
   output logic        UsbSweepTestStartStop,
   output logic        RunBusy,
   output logic        RunFinished,
   output logic        CommandError
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RUN_ACQ   = 2'd1,
      S_RUN_SWEEP = 2'd2,
      S_STOPPING  = 2'd3
   } state_t;

   localparam logic [3:0] OP_SET_MODE = 4'hA;
   localparam logic [3:0] OP_SET_DAC  = 4'hB;
   localparam logic [3:0] OP_START    = 4'hC;
   localparam logic [3:0] OP_STOP     = 4'hD;
   localparam logic [1:0] MODE_ACQ    = 2'b00;
   localparam logic [1:0] ARG_ILLEGAL = 2'b11;
   localparam logic [7:0] HOLD_LAST   = 8'(STOP_HOLD - 1);

   state_t      state, state_next;
   logic [7:0]  hold_cnt, hold_cnt_next;
   logic [1:0]  mode_q, mode_next;
   logic [1:0]  dac_q, dac_next;
   logic        acq_q, acq_next;
   logic        sweep_q, sweep_next;
   logic        busy_q, busy_next;
   logic        finished_q, finished_next;
   logic        error_q, error_next;
   logic        done_prev;
   logic        done_rise;
   logic [3:0]  opcode;
   logic [1:0]  arg;
   logic        unused_bits;

   assign opcode      = CommandWord[15:12];
   assign arg         = CommandWord[1:0];
   assign unused_bits = &{1'b0, CommandWord[11:2]};
   assign done_rise   = SweepTestDone & ~done_prev;

   always_ff @(posedge Clk) begin
      if (reset) begin
         state      <= S_IDLE;
         hold_cnt   <= 8'd0;
         mode_q     <= 2'b00;
         dac_q      <= 2'b00;
         acq_q      <= 1'b0;
         sweep_q    <= 1'b0;
         busy_q     <= 1'b0;
         finished_q <= 1'b0;
         error_q    <= 1'b0;
         done_prev  <= 1'b0;
      end else begin
         state      <= state_next;
         hold_cnt   <= hold_cnt_next;
         mode_q     <= mode_next;
         dac_q      <= dac_next;
         acq_q      <= acq_next;
         sweep_q    <= sweep_next;
         busy_q     <= busy_next;
         finished_q <= finished_next;
         error_q    <= error_next;
         done_prev  <= SweepTestDone;
      end
   end

   always_comb begin
      state_next    = state;
      hold_cnt_next = hold_cnt;
      mode_next     = mode_q;
      dac_next      = dac_q;
      acq_next      = acq_q;
      sweep_next    = sweep_q;
      finished_next = 1'b0;
      error_next    = 1'b0;

      case (state)
         S_IDLE: begin
            if (CommandWord_en) begin
               case (opcode)
                  OP_SET_MODE: begin
                     if (arg == ARG_ILLEGAL) error_next = 1'b1;
                     else                    mode_next  = arg;
                  end
                  OP_SET_DAC: dac_next = arg;
                  OP_START: begin
                     if (mode_q == MODE_ACQ) begin
                        acq_next   = 1'b1;
                        state_next = S_RUN_ACQ;
                     end else begin
                        sweep_next = 1'b1;
                        state_next = S_RUN_SWEEP;
                     end
                  end
                  OP_STOP: ;
                  default: error_next = 1'b1;
               endcase
            end
         end

         S_RUN_ACQ: begin
            if (CommandWord_en) begin
               if (opcode == OP_STOP) begin
                  acq_next      = 1'b0;
                  hold_cnt_next = 8'd0;
                  state_next    = S_STOPPING;
               end else begin
                  error_next = 1'b1;
               end
            end
         end

         S_RUN_SWEEP: begin
            // A done edge wins over a simultaneous STOP: the run completed normally.
            if (done_rise) begin
               sweep_next    = 1'b0;
               finished_next = 1'b1;
               state_next    = S_IDLE;
               if (CommandWord_en && opcode != OP_STOP) error_next = 1'b1;
            end else if (CommandWord_en) begin
               if (opcode == OP_STOP) begin
                  sweep_next    = 1'b0;
                  hold_cnt_next = 8'd0;
                  state_next    = S_STOPPING;
               end else begin
                  error_next = 1'b1;
               end
            end
         end

         S_STOPPING: begin
            if (CommandWord_en) error_next = 1'b1;
            if (hold_cnt == HOLD_LAST) begin
               hold_cnt_next = 8'd0;
               state_next    = S_IDLE;
            end else begin
               hold_cnt_next = hold_cnt + 8'd1;
            end
         end

         default: state_next = S_IDLE;
      endcase

      busy_next = (state_next != S_IDLE);
   end

   assign ModeSelect              = mode_q;
   assign DacSelect               = dac_q;
   assign UsbMicrorocAcqStartStop = acq_q;
   assign UsbSweepTestStartStop   = sweep_q;
   assign RunBusy                 = busy_q;
   assign RunFinished             = finished_q;
   assign CommandError            = error_q;

endmodule

// File: tb/tb_usb_mode_controller.sv
// tb/tb_usb_mode_controller.sv - vector table, directed corner sequences and randomized model check
module tb_usb_mode_controller;

   localparam int STOP_HOLD = 8;

   logic        Clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] CommandWord = 16'h0000;
   logic        CommandWord_en = 1'b0;
   logic        SweepTestDone = 1'b0;
   logic [1:0]  ModeSelect;
   logic [1:0]  DacSelect;
   logic        UsbMicrorocAcqStartStop;
   logic        UsbSweepTestStartStop;
   logic        RunBusy;
   logic        RunFinished;
   logic        CommandError;

   int checks = 0;
   int errors = 0;

   usb_mode_controller #(.STOP_HOLD(STOP_HOLD)) dut (
      .Clk(Clk),
      .reset(reset),
      .CommandWord(CommandWord),
      .CommandWord_en(CommandWord_en),
      .SweepTestDone(SweepTestDone),
      .ModeSelect(ModeSelect),
      .DacSelect(DacSelect),
      .UsbMicrorocAcqStartStop(UsbMicrorocAcqStartStop),
      .UsbSweepTestStartStop(UsbSweepTestStartStop),
      .RunBusy(RunBusy),
      .RunFinished(RunFinished),
      .CommandError(CommandError)
   );

   always #5 Clk = ~Clk;

   // Reference model: run kind 0 none / 1 acq / 2 sweep, plus a stop countdown.
   int         m_run = 0;
   int         m_hold = 0;
   logic [1:0] m_mode = 2'b00;
   logic [1:0] m_dac = 2'b00;
   logic       m_prev = 1'b0;
   logic       m_fin = 1'b0;
   logic       m_err = 1'b0;

   task automatic model_step(input logic r, input logic e, input logic [15:0] w, input logic d);
      logic       rise;
      logic [3:0] op;
      logic [1:0] a;
      m_fin = 1'b0;
      m_err = 1'b0;
      if (r) begin
         m_run = 0; m_hold = 0; m_mode = 2'b00; m_dac = 2'b00; m_prev = 1'b0;
         return;
      end
      rise   = d && !m_prev;
      m_prev = d;
      op     = w[15:12];
      a      = w[1:0];
      if (m_hold > 0) begin
         if (e) m_err = 1'b1;
         m_hold = m_hold - 1;
      end else if (m_run == 2 && rise) begin
         m_run = 0;
         m_fin = 1'b1;
         if (e && op != 4'hD) m_err = 1'b1;
      end else if (!e) begin
      end else if (m_run == 0) begin
         if (op == 4'hA) begin
            if (a == 2'b11) m_err = 1'b1;
            else            m_mode = a;
         end else if (op == 4'hB) m_dac = a;
         else if (op == 4'hC) m_run = (m_mode == 2'b00) ? 1 : 2;
         else if (op != 4'hD) m_err = 1'b1;
      end else if (op == 4'hD) begin
         m_run  = 0;
         m_hold = STOP_HOLD;
      end else begin
         m_err = 1'b1;
      end
   endtask

   function automatic logic [8:0] model_vec();
      return {m_mode, m_dac, m_run == 1, m_run == 2, (m_run != 0) || (m_hold > 0), m_fin, m_err};
   endfunction

   task automatic check(input string name, input logic [8:0] exp);
      logic [8:0] got;
      got = {ModeSelect, DacSelect, UsbMicrorocAcqStartStop, UsbSweepTestStartStop,
             RunBusy, RunFinished, CommandError};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b (mode dac acq sweep busy fin err)", name, got, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic e, input logic [15:0] w, input logic d);
      @(negedge Clk);
      reset = r; CommandWord_en = e; CommandWord = w; SweepTestDone = d;
      model_step(r, e, w, d);
      @(posedge Clk);
      #1;
      check("model", model_vec());
   endtask

   typedef struct {
      logic        rst;
      logic        en;
      logic [15:0] w;
      logic        done;
      logic [8:0]  exp;
   } vec_t;

   vec_t vecs[11];

   initial begin
      // expected field order: mode[2] dac[2] acq sweep busy fin err
      vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 9'b00_00_0_0_0_0_0};
      vecs[1]  = '{1'b0, 1'b1, 16'hA001, 1'b0, 9'b01_00_0_0_0_0_0};
      vecs[2]  = '{1'b0, 1'b1, 16'hC000, 1'b0, 9'b01_00_0_1_1_0_0};
      vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 9'b01_00_0_1_1_0_0};
      vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 9'b01_00_0_0_0_1_0};
      vecs[5]  = '{1'b0, 1'b1, 16'hA000, 1'b1, 9'b00_00_0_0_0_0_0};
      vecs[6]  = '{1'b0, 1'b1, 16'hC000, 1'b0, 9'b00_00_1_0_1_0_0};
      vecs[7]  = '{1'b0, 1'b1, 16'hB003, 1'b0, 9'b00_00_1_0_1_0_1};
      vecs[8]  = '{1'b0, 1'b1, 16'hA002, 1'b0, 9'b00_00_1_0_1_0_1};
      vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 9'b00_00_1_0_1_0_0};
      vecs[10] = '{1'b0, 1'b1, 16'hD000, 1'b0, 9'b00_00_0_0_1_0_0};

      for (int i = 0; i < 11; i++) begin
         cycle(vecs[i].rst, vecs[i].en, vecs[i].w, vecs[i].done);
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // STOPPING hold: eight rejected SET_MODEs, the ninth is accepted
      for (int i = 0; i < STOP_HOLD; i++) begin
         cycle(1'b0, 1'b1, 16'hA002, 1'b0);
         check($sformatf("stop_hold%0d", i), {4'b00_00, 1'b0, 1'b0, i < STOP_HOLD - 1, 1'b0, 1'b1});
      end
      cycle(1'b0, 1'b1, 16'hA002, 1'b0);
      check("stop_hold_release", 9'b10_00_0_0_0_0_0);

      // IDLE rejects and silent STOP
      cycle(1'b0, 1'b1, 16'hA003, 1'b0);
      check("idle_mode11", 9'b10_00_0_0_0_0_1);
      cycle(1'b0, 1'b1, 16'h7000, 1'b0);
      check("idle_badop", 9'b10_00_0_0_0_0_1);
      cycle(1'b0, 1'b1, 16'hD000, 1'b0);
      check("idle_stop", 9'b10_00_0_0_0_0_0);

      // Back-to-back DAC writes, ignored middle bits
      cycle(1'b0, 1'b1, 16'hB002, 1'b0);
      check("dac_b2b_a", 9'b10_10_0_0_0_0_0);
      cycle(1'b0, 1'b1, 16'hBFFD, 1'b0);
      check("dac_b2b_b", 9'b10_01_0_0_0_0_0);

      // STOP and done edge together count as done; immediate restart with done held high
      cycle(1'b0, 1'b1, 16'hC000, 1'b0);
      check("sweep_start", 9'b10_01_0_1_1_0_0);
      cycle(1'b0, 1'b1, 16'hD000, 1'b1);
      check("stop_and_done", 9'b10_01_0_0_0_1_0);
      cycle(1'b0, 1'b1, 16'hC000, 1'b1);
      check("restart", 9'b10_01_0_1_1_0_0);
      cycle(1'b0, 1'b0, 16'h0000, 1'b1);
      check("done_held_no_edge", 9'b10_01_0_1_1_0_0);
      cycle(1'b0, 1'b0, 16'h0000, 1'b0);
      check("done_low", 9'b10_01_0_1_1_0_0);
      cycle(1'b0, 1'b0, 16'h0000, 1'b1);
      check("done_reedge", 9'b10_01_0_0_0_1_0);

      // Reset mid-sweep with a STOP strobed in the same cycle
      cycle(1'b0, 1'b1, 16'hC000, 1'b0);
      check("sweep_again", 9'b10_01_0_1_1_0_0);
      cycle(1'b1, 1'b1, 16'hD000, 1'b1);
      check("reset_midrun", 9'b00_00_0_0_0_0_0);
      cycle(1'b0, 1'b0, 16'h0000, 1'b1);
      check("after_reset", 9'b00_00_0_0_0_0_0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         logic [3:0]  op;
         logic [15:0] w;
         logic        d;
         case ($urandom_range(0, 5))
            0: op = 4'hA;
            1: op = 4'hB;
            2: op = 4'hC;
            3: op = 4'hD;
            4: op = 4'hD;
            default: op = 4'($urandom);
         endcase
         w = {op, 10'($urandom), 2'($urandom)};
         d = ($urandom_range(0, 3) == 0) ? ~SweepTestDone : SweepTestDone;
         cycle($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, w, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
